pulse_blinker: RTL and testbench



---
 rtl/pulse_blinker_pkg.sv | 21 ++
 rtl/pulse_blinker.sv | 125 ++++++++++++
 tb/tb_pulse_blinker.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pulse_blinker_pkg.sv
// pulse_blinker_pkg -- shared types and default timing for the blinker.
//   blink_state_t : FSM encoding (IDLE / ON / OFF)
//   DEF_*         : default parameter values (50 MHz board clock)
//   max2()        : elaboration-time helper for sizing the shared timer
package pulse_blinker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } blink_state_t;

  localparam int DEF_ON_CYCLES   = 12_500_000;  // 250 ms at 50 MHz
  localparam int DEF_OFF_CYCLES  = 12_500_000;  // 250 ms at 50 MHz
  localparam int DEF_MAX_PENDING = 15;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_blinker.sv
// pulse_blinker -- turns each event strobe into one human-visible blink,
// queueing events that arrive while a blink (or its off gap) is running.
//   i_clk      : system clock
//   i_rst_n    : asynchronous active-low reset
//   i_pulse    : event strobe, one event per high cycle
//   i_clear    : synchronous flush (drop queue, abort blink)
//   o_led      : blink output, high only in ON
//   o_busy     : high whenever the FSM is not IDLE
//   o_pending  : queued events not yet blinked (saturating)
//   o_drop     : one-cycle strobe when an event is lost to saturation
// All outputs are registered; o_led/o_busy are decoded from the next state.
module pulse_blinker
  import pulse_blinker_pkg::*;
#(
  parameter int ON_CYCLES   = DEF_ON_CYCLES,
  parameter int OFF_CYCLES  = DEF_OFF_CYCLES,
  parameter int MAX_PENDING = DEF_MAX_PENDING
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_pulse,
  input  logic                               i_clear,
  output logic                               o_led,
  output logic                               o_busy,
  output logic [$clog2(MAX_PENDING+1)-1:0]   o_pending,
  output logic                               o_drop
);

  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam int TW = $clog2(max2(ON_CYCLES, OFF_CYCLES) + 1);

  // Timer counts down to 0; the cycle it reads 0 is the last of the phase.
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

  blink_state_t  state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          drop_d;
  logic          consume;
  logic          last;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pend_d  = pend_q;
    drop_d  = 1'b0;
    consume = 1'b0;
    last    = (timer_q == '0);

    case (state_q)
      IDLE: begin
        if (i_pulse || pend_q != '0) begin
          consume = 1'b1;
          state_d = ON;
          timer_d = ON_LOAD;
        end
      end
      ON: begin
        if (last) begin
          state_d = OFF;
          timer_d = OFF_LOAD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      OFF: begin
        if (last) begin
          if (i_pulse || pend_q != '0) begin
            consume = 1'b1;
            state_d = ON;
            timer_d = ON_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    // Net queue change is pulse - consume. A consume with an empty queue
    // can only happen with i_pulse high, so the pulse is taken directly and
    // the count is unchanged; the decrement branch never underflows.
    if (i_pulse && !consume) begin
      if (pend_q == PEND_MAX) drop_d = 1'b1;
      else                    pend_d = pend_q + 1'b1;
    end else if (!i_pulse && consume) begin
      pend_d = pend_q - 1'b1;
    end

    if (i_clear) begin
      state_d = IDLE;
      timer_d = '0;
      pend_d  = '0;
      drop_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      pend_q    <= '0;
      o_led     <= 1'b0;
      o_busy    <= 1'b0;
      o_drop    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pend_q    <= pend_d;
      o_led     <= (state_d == ON);
      o_busy    <= (state_d != IDLE);
      o_drop    <= drop_d;
    end
  end

  assign o_pending = pend_q;

endmodule

// File: tb/tb_pulse_blinker.sv
// tb_pulse_blinker -- directed checks with ON_CYCLES=4, OFF_CYCLES=3,
// MAX_PENDING=3. "Cycle n" values are sampled 1 time unit after the edge
// that opens cycle n; an input driven in cycle n is seen at the edge ending it.
module tb_pulse_blinker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pulse = 1'b0;
  logic       clear = 1'b0;
  logic       led, busy, drop;
  logic [1:0] pend;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pulse_blinker #(.ON_CYCLES(4), .OFF_CYCLES(3), .MAX_PENDING(3)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_pulse  (pulse),
    .i_clear  (clear),
    .o_led    (led),
    .o_busy   (busy),
    .o_pending(pend),
    .o_drop   (drop)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic l, input logic b,
                         input logic [1:0] p, input logic d);
    chk({tag, ".led"},  32'(led),  32'(l));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".pend"}, 32'(pend), 32'(p));
    chk({tag, ".drop"}, 32'(drop), 32'(d));
  endtask

  // Runs n cycles and counts rising edges of led.
  task automatic run_count(input int n, output int rises);
    logic prev;
    prev  = led;
    rises = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (led && !prev) rises++;
      prev = led;
    end
  endtask

  initial begin
    int rises;

    // Reset
    #1 rst_n = 1'b0;
    tick(); tick();
    chk_all("reset", 1'b0, 1'b0, 2'd0, 1'b0);
    rst_n = 1'b1;
    tick(); tick();
    chk_all("post_reset_idle", 1'b0, 1'b0, 2'd0, 1'b0);

    // Single pulse: ON 4 cycles, OFF 3, then IDLE
    pulse = 1'b1; tick(); pulse = 1'b0;
    chk_all("single.c11", 1'b1, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("single.on_led", 32'(led), 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("single.off", 1'b0, 1'b1, 2'd0, 1'b0);
    end
    tick();
    chk_all("single.idle", 1'b0, 1'b0, 2'd0, 1'b0);

    // Pulses at 10, 12, 13 -> blinks start 11, 18, 25
    tick();
    pulse = 1'b1; tick(); pulse = 1'b0;                 // c11
    chk("q.c11_led", 32'(led), 32'd1);
    tick();                                             // c12
    pulse = 1'b1; tick();                               // c13
    chk("q.c13_pend", 32'(pend), 32'd1);
    tick(); pulse = 1'b0;                               // c14
    chk("q.c14_pend", 32'(pend), 32'd2);
    tick(); tick(); tick();                             // c17
    chk_all("q.c17", 1'b0, 1'b1, 2'd2, 1'b0);
    tick();                                             // c18
    chk_all("q.c18", 1'b1, 1'b1, 2'd1, 1'b0);
    for (int i = 0; i < 6; i++) tick();                 // c24
    chk_all("q.c24", 1'b0, 1'b1, 2'd1, 1'b0);
    tick();                                             // c25
    chk_all("q.c25", 1'b1, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 7; i++) tick();                 // c32
    chk_all("q.idle", 1'b0, 1'b0, 2'd0, 1'b0);

    // Pulse on last OFF cycle with empty queue: back-to-back blink
    pulse = 1'b1; tick(); pulse = 1'b0;                 // c11
    for (int i = 0; i < 6; i++) tick();                 // c17
    chk_all("b2b.c17", 1'b0, 1'b1, 2'd0, 1'b0);
    pulse = 1'b1; tick(); pulse = 1'b0;                 // c18
    chk_all("b2b.c18", 1'b1, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 7; i++) tick();                 // c25
    chk_all("b2b.idle", 1'b0, 1'b0, 2'd0, 1'b0);

    // Saturation: starting pulse at 10 plus five more (11..15)
    pulse = 1'b1; tick();                               // c11
    chk("sat.c11_led", 32'(led), 32'd1);
    tick(); tick(); tick();                             // c14
    chk_all("sat.c14", 1'b1, 1'b1, 2'd3, 1'b0);
    tick();                                             // c15
    chk_all("sat.c15", 1'b0, 1'b1, 2'd3, 1'b1);
    tick(); pulse = 1'b0;                               // c16
    chk_all("sat.c16", 1'b0, 1'b1, 2'd3, 1'b1);
    tick();                                             // c17
    chk_all("sat.c17", 1'b0, 1'b1, 2'd3, 1'b0);
    run_count(30, rises);
    chk("sat.more_blinks", 32'(rises), 32'd3);
    chk_all("sat.idle", 1'b0, 1'b0, 2'd0, 1'b0);

    // Clear during ON with pending=2 and simultaneous pulse
    pulse = 1'b1; tick(); tick(); tick(); pulse = 1'b0; // c13, pend 2
    chk_all("clr.before", 1'b1, 1'b1, 2'd2, 1'b0);
    clear = 1'b1; pulse = 1'b1; tick(); clear = 1'b0; pulse = 1'b0;
    chk_all("clr.after", 1'b0, 1'b0, 2'd0, 1'b0);
    run_count(20, rises);
    chk("clr.no_blinks", 32'(rises), 32'd0);

    // Async reset mid-OFF with pending=1
    pulse = 1'b1; tick(); tick(); pulse = 1'b0;         // c12, pend 1
    chk("rst.pend", 32'(pend), 32'd1);
    for (int i = 0; i < 4; i++) tick();                 // c16 (mid-OFF)
    chk_all("rst.midoff", 1'b0, 1'b1, 2'd1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_all("rst.async", 1'b0, 1'b0, 2'd0, 1'b0);
    tick();
    rst_n = 1'b1;
    run_count(20, rises);
    chk("rst.no_blinks", 32'(rises), 32'd0);
    chk_all("rst.idle", 1'b0, 1'b0, 2'd0, 1'b0);
    pulse = 1'b1; tick(); pulse = 1'b0;
    chk_all("rst.new_pulse", 1'b1, 1'b1, 2'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
